// File: rtl/mbx_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mbx_arb_pkg
// Shared types and constants for the mailbox access arbiter.
// Holds the arbiter FSM state type and the register-select encodings that
// come from request address bits [3:2].
// No ports (package).
// -----------------------------------------------------------------------------
package mbx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_STS  = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

endpackage

// File: rtl/mbx_access_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mbx_rr_arbiter
// Combinational round-robin pick: returns the first asserted request at or
// after the pointer, wrapping around. The pointer register lives in the parent.
// Ports:
//   req_i      in   NUM_REQ   request vector
//   ptr_i      in   IDX_W     highest-priority index this round
//   grant_o    out  IDX_W     winning index (0 when no request)
//   any_req_o  out  1         at least one request asserted
// -----------------------------------------------------------------------------
module mbx_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_req_o
);

  // Walk the offsets from farthest to nearest so the last hit, i.e. the
  // request closest to the pointer, is the one that sticks.
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
        grant_o   = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbx_access_arbiter.sv
// -----------------------------------------------------------------------------
// mbx_access_arbiter
// Shares the register ports of NUM_CH mailbox channels among NUM_REQ bus
// requesters. One transaction at a time, round-robin between requesters.
// Address decode: addr[3:2] = register select (ctrl/data/status),
// addr[ADDR_W-1:4] = channel index.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   req_valid_i    per-requester request pending (held until req_ready_o)
//   req_write_i    per-requester 1=write 0=read
//   req_addr_i     packed per-requester address
//   req_wdata_i    packed per-requester write data
//   req_ready_o    1-cycle accept pulse to the granted requester
//   rsp_valid_o    1-cycle completion pulse to the granted requester
//   rsp_rdata_o    read data, valid with rsp_valid_o
//   rsp_err_o      decode / empty-read error, valid with rsp_valid_o
//   ch_wen_o       per-channel one-hot write strobe {status,data,ctrl}
//   ch_ren_o       per-channel one-hot read strobe {status,data,ctrl}
//   ch_wdata_o     write data broadcast to all channels
//   ch_rdata_i     packed per-channel read data
//   ch_empty_i     per-channel data FIFO empty
// -----------------------------------------------------------------------------
module mbx_access_arbiter
  import mbx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*32-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [31:0]            rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic [NUM_CH*3-1:0]    ch_wen_o,
  output logic [NUM_CH*3-1:0]    ch_ren_o,
  output logic [31:0]            ch_wdata_o,
  input  logic [NUM_CH*32-1:0]   ch_rdata_i,
  input  logic [NUM_CH-1:0]      ch_empty_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CHF_W = ADDR_W - 4;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q;
  logic               write_q;
  logic [ADDR_W-3:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic [IDX_W-1:0]   arb_grant;
  logic               arb_any;

  logic [1:0]         reg_sel;
  logic [CHF_W-1:0]   ch_field;
  logic [CH_W-1:0]    ch_idx;
  logic               dec_err;
  logic               data_rd;
  logic               empty_rd;
  logic               pop_rd;
  logic [31:0]        sel_rdata;

  mbx_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .grant_o   (arb_grant),
    .any_req_o (arb_any)
  );

  // addr_q drops the two byte-offset bits, so reg_sel sits at [1:0].
  assign reg_sel   = addr_q[1:0];
  assign ch_field  = addr_q[ADDR_W-3:2];
  assign ch_idx    = ch_field[CH_W-1:0];
  assign dec_err   = (reg_sel == REG_RSVD) || (32'(ch_field) >= 32'(NUM_CH));
  assign data_rd   = !write_q && !dec_err && (reg_sel == REG_DATA);
  // A data read on an empty FIFO must never strobe ren; it becomes an error.
  assign empty_rd  = data_rd && ch_empty_i[ch_idx];
  assign pop_rd    = data_rd && !ch_empty_i[ch_idx];
  assign sel_rdata = ch_rdata_i[int'(ch_idx)*32 +: 32];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE:  if (arb_any) state_d = ISSUE;
      ISSUE: state_d = pop_rd ? WAIT : RESP;
      WAIT:  state_d = RESP;
      RESP: begin
        state_d  = IDLE;
        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction context: latched at grant, read data captured in ISSUE for
  // ctrl/status and in WAIT for the FIFO data register (dout lags ren).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_grant;
            write_q <= req_write_i[arb_grant];
            addr_q  <= req_addr_i[int'(arb_grant)*ADDR_W + 2 +: ADDR_W-2];
            wdata_q <= req_wdata_i[int'(arb_grant)*32 +: 32];
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ISSUE: begin
          err_q <= dec_err || empty_rd;
          if (!write_q && !dec_err && (reg_sel != REG_DATA)) rdata_q <= sel_rdata;
        end
        WAIT: rdata_q <= sel_rdata;
        default: ;
      endcase
    end
  end

  // Outputs are forced low while rstn is asserted so a reset landing
  // mid-transaction never leaks a strobe or response.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    ch_wen_o    = '0;
    ch_ren_o    = '0;
    ch_wdata_o  = '0;
    if (rstn) begin
      ch_wdata_o = wdata_q;
      case (state_q)
        IDLE: if (arb_any) req_ready_o[arb_grant] = 1'b1;
        ISSUE: begin
          if (!dec_err) begin
            if (write_q) ch_wen_o[int'(ch_idx)*3 + int'(reg_sel)] = 1'b1;
            else if (!empty_rd) ch_ren_o[int'(ch_idx)*3 + int'(reg_sel)] = 1'b1;
          end
        end
        RESP: begin
          rsp_valid_o[grant_q] = 1'b1;
          rsp_rdata_o          = rdata_q;
          rsp_err_o            = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mbx_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mbx_access_arbiter
// Self-checking bench for mbx_access_arbiter. A transaction-level reference
// model predicts grants, strobes and responses cycle by cycle from the
// arbitration and decode rules; directed cases cover the documented scenarios
// and random traffic covers the rest.
// -----------------------------------------------------------------------------
module tb_mbx_access_arbiter;

  localparam int NUM_REQ = 4;
  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 8;

  logic                        clk = 1'b0;
  logic                        rstn;
  logic [NUM_REQ-1:0]          reqValid;
  logic [NUM_REQ-1:0]          reqWrite;
  logic [NUM_REQ*ADDR_W-1:0]   reqAddr;
  logic [NUM_REQ*32-1:0]       reqWdata;
  logic [NUM_REQ-1:0]          reqReady;
  logic [NUM_REQ-1:0]          rspValid;
  logic [31:0]                 rspRdata;
  logic                        rspErr;
  logic [NUM_CH*3-1:0]         chWen;
  logic [NUM_CH*3-1:0]         chRen;
  logic [31:0]                 chWdata;
  logic [NUM_CH*32-1:0]        chRdata;
  logic [NUM_CH-1:0]           chEmpty;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state
  bit          mBusy;
  int          mK, mLen, mGrant, mPtr, mCh;
  bit          mWrite, mErr;
  logic [7:0]  mAddr;
  logic [31:0] mWdata, mRdata;
  bit [NUM_REQ-1:0] dropNext;
  int          grantLog[$];

  mbx_access_arbiter #(
    .NUM_REQ (NUM_REQ),
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (reqValid),
    .req_write_i (reqWrite),
    .req_addr_i  (reqAddr),
    .req_wdata_i (reqWdata),
    .req_ready_o (reqReady),
    .rsp_valid_o (rspValid),
    .rsp_rdata_o (rspRdata),
    .rsp_err_o   (rspErr),
    .ch_wen_o    (chWen),
    .ch_ren_o    (chRen),
    .ch_wdata_o  (chWdata),
    .ch_rdata_i  (chRdata),
    .ch_empty_i  (chEmpty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBusy    = 1'b0;
    mK       = 0;
    mLen     = 2;
    mPtr     = 0;
    dropNext = '0;
    grantLog.delete();
  endtask

  // One cycle of the reference model, called mid-cycle after inputs settle.
  task automatic modelStep();
    logic [NUM_REQ-1:0]  expReady, expRspValid;
    logic [NUM_CH*3-1:0] expWen, expRen;
    int w, sel;
    bit decErr;
    expReady    = '0;
    expRspValid = '0;
    expWen      = '0;
    expRen      = '0;
    w = -1;
    if (mBusy) mK++;
    if (!mBusy) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        if (w < 0 && reqValid[(mPtr + off) % NUM_REQ]) w = (mPtr + off) % NUM_REQ;
      end
    end
    if (w >= 0) expReady[w] = 1'b1;
    checkOutput("ready", 64'(reqReady), 64'(expReady));

    if (mBusy && mK == 1) begin
      mCh    = int'(mAddr[7:4]);
      sel    = int'(mAddr[3:2]);
      decErr = (sel == 3) || (mCh >= NUM_CH);
      mRdata = '0;
      mErr   = 1'b0;
      mLen   = 2;
      if (decErr) mErr = 1'b1;
      else if (mWrite) begin
        expWen[mCh*3 + sel] = 1'b1;
        checkOutput("wdata", 64'(chWdata), 64'(mWdata));
      end else if (sel == 1) begin
        if (chEmpty[mCh]) mErr = 1'b1;
        else begin
          expRen[mCh*3 + 1] = 1'b1;
          mLen = 3;
        end
      end else begin
        expRen[mCh*3 + sel] = 1'b1;
        mRdata = chRdata[mCh*32 +: 32];
      end
    end
    if (mBusy && mK == 2 && mLen == 3) mRdata = chRdata[mCh*32 +: 32];
    checkOutput("wen", 64'(chWen), 64'(expWen));
    checkOutput("ren", 64'(chRen), 64'(expRen));

    if (mBusy && mK == mLen) expRspValid[mGrant] = 1'b1;
    checkOutput("rspValid", 64'(rspValid), 64'(expRspValid));
    if (expRspValid != '0) begin
      checkOutput("rspRdata", 64'(rspRdata), 64'(mRdata));
      checkOutput("rspErr", 64'(rspErr), 64'(mErr));
      mBusy = 1'b0;
      mPtr  = (mGrant + 1) % NUM_REQ;
    end

    if (w >= 0) begin
      mBusy  = 1'b1;
      mK     = 0;
      mGrant = w;
      mWrite = reqWrite[w];
      mAddr  = reqAddr[w*8 +: 8];
      mWdata = reqWdata[w*32 +: 32];
      dropNext[w] = 1'b1;
      grantLog.push_back(w);
    end
  endtask

  task automatic randomChannels();
    for (int c = 0; c < NUM_CH; c++) chRdata[c*32 +: 32] = $urandom;
    chEmpty = NUM_CH'($urandom);
  endtask

  // One clock of random traffic: accepted requesters drop, idle requesters
  // raise a new request with probability raisePct.
  task automatic applyStimulus(input int raisePct);
    @(posedge clk);
    #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (dropNext[r] || !reqValid[r]) begin
        if (int'($urandom_range(0, 99)) < raisePct) begin
          reqValid[r]           = 1'b1;
          reqWrite[r]           = 1'($urandom);
          reqAddr[r*8 +: 8]     = {4'($urandom_range(0, 5)), 2'($urandom), 2'b00};
          reqWdata[r*32 +: 32]  = $urandom;
        end else begin
          reqValid[r] = 1'b0;
        end
      end
    end
    dropNext = '0;
    randomChannels();
    #1;
    modelStep();
  endtask

  task automatic applyReset(input int cycles);
    rstn     = 1'b0;
    reqValid = '0;
    modelReset();
    repeat (cycles) begin
      @(posedge clk);
      #2;
      checkOutput("rstStrobes", {31'd0, reqReady, rspValid, rspErr, chWen, chRen}, 64'd0);
      checkOutput("rstData", {rspRdata, chWdata}, 64'd0);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    modelStep();
  endtask

  task automatic runDirected(input int r, input bit wr, input logic [7:0] addr,
                             input logic [31:0] wd, input logic [NUM_CH-1:0] empty,
                             input logic [31:0] rdVal, input int expLat,
                             input logic [31:0] expRdata, input bit expErr);
    int lat;
    bit seen;
    @(posedge clk);
    #1;
    reqValid             = '0;
    reqValid[r]          = 1'b1;
    reqWrite[r]          = wr;
    reqAddr[r*8 +: 8]    = addr;
    reqWdata[r*32 +: 32] = wd;
    chEmpty              = empty;
    chRdata              = {NUM_CH{rdVal}};
    dropNext             = '0;
    #1;
    checkOutput("dirReady", 64'(reqReady), 64'(1 << r));
    modelStep();
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (dropNext[r]) reqValid[r] = 1'b0;
      dropNext = '0;
      #1;
      modelStep();
      lat++;
      if (rspValid[r]) begin
        seen = 1'b1;
        checkOutput("dirLatency", 64'(lat), 64'(expLat));
        checkOutput("dirRdata", 64'(rspRdata), 64'(expRdata));
        checkOutput("dirErr", 64'(rspErr), 64'(expErr));
      end
    end
    if (!seen) checkOutput("dirRspTimeout", 64'd0, 64'd1);
  endtask

  initial begin
    int expSeq[5];
    bit reached;
    expSeq   = '{0, 1, 2, 3, 0};
    rstn     = 1'b0;
    reqValid = '0;
    reqWrite = '0;
    reqAddr  = '0;
    reqWdata = '0;
    chRdata  = '0;
    chEmpty  = '0;
    modelReset();
    applyReset(3);

    // Directed scenarios
    runDirected(0, 1'b1, 8'h10, 32'h8000_4000, 4'h0, 32'h0,         2, 32'h0,         1'b0);
    runDirected(1, 1'b0, 8'h28, 32'h0,         4'h0, 32'h3,         2, 32'h3,         1'b0);
    runDirected(2, 1'b0, 8'h04, 32'h0,         4'h0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0);
    runDirected(3, 1'b0, 8'h04, 32'h0,         4'h1, 32'h1234_5678, 2, 32'h0,         1'b1);
    runDirected(0, 1'b0, 8'h0C, 32'h0,         4'h0, 32'h5555_AAAA, 2, 32'h0,         1'b1);
    runDirected(1, 1'b1, 8'h50, 32'hCAFE_0001, 4'h0, 32'h0,         2, 32'h0,         1'b1);

    // Random traffic
    repeat (1500) applyStimulus(60);

    // Reset while a data read sits in the FIFO-latency cycle
    applyReset(2);
    @(posedge clk);
    #1;
    reqValid       = 4'b0100;
    reqWrite[2]    = 1'b0;
    reqAddr[23:16] = 8'h04;
    chEmpty        = '0;
    dropNext       = '0;
    #1;
    modelStep();
    reached = 1'b0;
    for (int i = 0; i < 5 && !reached; i++) begin
      @(posedge clk);
      #1;
      if (dropNext[2]) reqValid[2] = 1'b0;
      dropNext = '0;
      for (int c = 0; c < NUM_CH; c++) chRdata[c*32 +: 32] = $urandom;
      chEmpty = '0;
      #1;
      modelStep();
      if (mBusy && mK == 2) reached = 1'b1;
    end
    checkOutput("waitReached", 64'(reached), 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("rstInWait", {31'd0, reqReady, rspValid, rspErr, chWen, chRen}, 64'd0);
    applyReset(2);

    // All requesters continuously valid: strict rotation from R0
    applyStimulus(100);
    checkOutput("grantAfterReset", 64'(reqReady), 64'h1);
    repeat (24) applyStimulus(100);
    checkOutput("grantCount", 64'(grantLog.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < grantLog.size()) checkOutput("grantSeq", 64'(grantLog[i]), 64'(expSeq[i]));
    end

    repeat (300) applyStimulus(40);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
